// File: rtl/mesh_config_loader.sv
// Buffers ROWS*COLS host configuration words in row-major order, then on launch streams
// them to the mesh one column at a time (one word per row) under a valid/ready handshake.
module mesh_config_loader #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CFG_W = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CFG_W-1:0]                 in_data,
    input  logic                             launch,
    input  logic                             clear,
    output logic [ROWS*CFG_W-1:0]            cfg_port,
    output logic                             cfg_valid,
    input  logic                             cfg_ready,
    output logic [$clog2(COLS)-1:0]          cfg_col,
    output logic                             done,
    output logic [$clog2(ROWS*COLS+1)-1:0]   fill_count
);

    localparam int DEPTH = ROWS * COLS;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int PTR_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {FILL, LOADED, ISSUE, DONE} state_t;

    state_t                  r_state;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [COL_W-1:0]        r_cfg_col;
    logic                    r_cfg_valid;
    logic                    r_done;
    logic                    r_in_ready;
    logic [ROWS*CFG_W-1:0]   r_cfg_port;
    logic [CFG_W-1:0]        r_buf [ROWS][COLS];

    logic [ROW_W-1:0]        w_wr_row;
    logic [COL_W-1:0]        w_wr_col;
    logic                    w_wr_en;
    logic                    w_last_word;
    logic [COL_W-1:0]        w_rd_col;
    logic [ROWS*CFG_W-1:0]   w_col_data;
    logic                    w_col_acc;
    logic                    w_last_col;

    assign w_wr_row    = ROW_W'(r_wr_ptr / PTR_W'(COLS));
    assign w_wr_col    = COL_W'(r_wr_ptr % PTR_W'(COLS));
    assign w_wr_en     = (r_state == FILL) && in_valid && !clear && !reset;
    assign w_last_word = (r_wr_ptr == PTR_W'(DEPTH - 1));
    assign w_col_acc   = r_cfg_valid && cfg_ready;
    assign w_last_col  = (r_cfg_col == COL_W'(COLS - 1));

    // Column to present next: column 0 on launch, otherwise the one after the current
    assign w_rd_col = (r_state == ISSUE) ? r_cfg_col + COL_W'(1) : '0;

    for (genvar g = 0; g < ROWS; g++) begin : g_rd
        assign w_col_data[g*CFG_W +: CFG_W] = r_buf[g][w_rd_col];
    end

    // Storage is deliberately not reset; contents are only meaningful once refilled
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_row][w_wr_col] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FILL;
            r_wr_ptr    <= '0;
            r_cfg_col   <= '0;
            r_cfg_valid <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cfg_port  <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (clear) begin
                        r_wr_ptr <= '0;
                    end else if (in_valid) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                        if (w_last_word) begin
                            r_state    <= LOADED;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                LOADED: begin
                    if (clear) begin
                        r_state    <= FILL;
                        r_wr_ptr   <= '0;
                        r_in_ready <= 1'b1;
                    end else if (launch) begin
                        r_state     <= ISSUE;
                        r_cfg_col   <= '0;
                        r_cfg_valid <= 1'b1;
                        r_cfg_port  <= w_col_data;
                    end
                end
                ISSUE: begin
                    if (w_col_acc) begin
                        if (w_last_col) begin
                            r_state     <= DONE;
                            r_cfg_col   <= '0;
                            r_cfg_valid <= 1'b0;
                            r_cfg_port  <= '0;
                            r_done      <= 1'b1;
                        end else begin
                            r_cfg_col  <= r_cfg_col + COL_W'(1);
                            r_cfg_port <= w_col_data;
                        end
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
                    if (clear) begin
                        r_state    <= FILL;
                        r_wr_ptr   <= '0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_state <= LOADED;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign cfg_port   = r_cfg_port;
    assign cfg_valid  = r_cfg_valid;
    assign cfg_col    = r_cfg_col;
    assign done       = r_done;
    assign fill_count = r_wr_ptr;

endmodule
